// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences the external PC register through an
// instruction-memory request/ack handshake, holds the fetched word for decode,
// and steers the PC on branch redirects and exception entry.
//
// state | meaning
// ------+-------------------------------------------------------------
// BOOT  | one cycle after reset; no request, stray acks ignored
// FETCH | ImReq high at ImAddr=PC, waiting for ImAck
// HOLD  | fetched word held in Ir/IrPc, waiting for decode to accept
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h00003000,
    parameter logic [31:0] EXC_VEC  = 32'h00004180
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PC,
    output logic [31:0] NPC,
    output logic        PcEn,
    output logic        ImReq,
    output logic [31:0] ImAddr,
    input  logic        ImAck,
    input  logic [31:0] ImRdata,
    output logic        IrValid,
    output logic [31:0] Ir,
    output logic [31:0] IrPc,
    input  logic        IdReady,
    input  logic        RedirValid,
    input  logic [31:0] RedirTarget,
    input  logic        ExcReq,
    output logic [15:0] RetCnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_kill;
    logic        r_pend_exc;
    logic [31:0] r_pend_addr;
    logic [31:0] r_ir;
    logic [31:0] r_ir_pc;
    logic [15:0] r_ret_cnt;

    logic        w_redir_now;
    logic [31:0] w_redir_tgt;
    logic [31:0] w_redir_addr;
    logic [31:0] w_ack_addr;
    logic        w_ack_drop;
    logic [31:0] w_pc_inc;
    logic [31:0] w_npc;
    logic        w_pc_en;

    // Target alignment is enforced by masking rather than slicing so that every
    // RedirTarget bit stays connected.
    assign w_redir_now  = RedirValid | ExcReq;
    assign w_redir_tgt  = RedirTarget & 32'hFFFF_FFFC;
    assign w_redir_addr = ExcReq ? EXC_VEC : w_redir_tgt;
    // A pending exception always holds EXC_VEC, so a same-cycle ExcReq yields
    // the same address either way; otherwise the older pending redirect wins.
    assign w_ack_addr   = ExcReq ? EXC_VEC : (r_kill ? r_pend_addr : w_redir_addr);
    assign w_ack_drop   = ImAck & (r_kill | w_redir_now);
    assign w_pc_inc     = PC + 32'd4;

    // PC load enable and next-PC select; NPC defaults to PC+4 when not loading.
    always_comb begin
        w_pc_en = 1'b0;
        w_npc   = w_pc_inc;
        case (r_state)
            BOOT, HOLD: begin
                if (w_redir_now) begin
                    w_pc_en = 1'b1;
                    w_npc   = w_redir_addr;
                end
            end
            FETCH: begin
                if (ImAck) begin
                    w_pc_en = 1'b1;
                    if (w_ack_drop) begin
                        w_npc = w_ack_addr;
                    end
                end
            end
            default: begin
                w_pc_en = 1'b0;
                w_npc   = w_pc_inc;
            end
        endcase
    end

    assign NPC     = w_npc & 32'hFFFF_FFFC;
    assign PcEn    = w_pc_en;
    assign ImReq   = (r_state == FETCH);
    assign ImAddr  = PC;
    assign IrValid = (r_state == HOLD);
    assign Ir      = r_ir;
    assign IrPc    = r_ir_pc;
    assign RetCnt  = r_ret_cnt;

    // Fetch sequencing, instruction hold register, redirect kill/pending tracking
    // and retire counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= BOOT;
            r_kill      <= 1'b0;
            r_pend_exc  <= 1'b0;
            r_pend_addr <= 32'h0;
            r_ir        <= 32'h0;
            r_ir_pc     <= RESET_PC;
            r_ret_cnt   <= 16'h0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (ImAck) begin
                        if (w_ack_drop) begin
                            // Word belongs to the abandoned path; refetch at the new PC.
                            r_kill     <= 1'b0;
                            r_pend_exc <= 1'b0;
                        end else begin
                            r_ir    <= ImRdata;
                            r_ir_pc <= PC;
                            r_state <= HOLD;
                        end
                    end else if (w_redir_now) begin
                        // Request must stay up until ack, so remember where to go.
                        r_kill <= 1'b1;
                        if (ExcReq) begin
                            r_pend_addr <= EXC_VEC;
                            r_pend_exc  <= 1'b1;
                        end else if (!(r_kill && r_pend_exc)) begin
                            r_pend_addr <= w_redir_tgt;
                            r_pend_exc  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (w_redir_now) begin
                        r_state <= FETCH;
                    end else if (IdReady) begin
                        r_state   <= FETCH;
                        r_ret_cnt <= r_ret_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL use clock Clk and reset Reset, asynchronous, active-high.
REQ-002 Parameter RESET_PC, default 32'h00003000, boot address; it SHALL equal the PC register reset value.
REQ-003 Parameter EXC_VEC, default 32'h00004180, exception entry address.
REQ-004 Ports SHALL be:
  Clk  in  1  clock
  Reset  in  1  async active-high reset
  PC  in  32  current value of the PC register
  NPC  out  32  next-PC value to the PC register
  PcEn  out  1  PC register load enable
  ImReq  out  1  instruction memory request, level
  ImAddr  out  32  instruction memory address
  ImAck  in  1  one-cycle pulse: ImRdata valid
  ImRdata  in  32  fetched instruction word
  IrValid  out  1  instruction available to decode
  Ir  out  32  held instruction
  IrPc  out  32  address of held instruction
  IdReady  in  1  decode accepts when IrValid & IdReady
  RedirValid  in  1  branch/jump redirect, one-cycle pulse
  RedirTarget  in  32  redirect address
  ExcReq  in  1  exception entry, one-cycle pulse
  RetCnt  out  16  count of accepted instructions

Function
REQ-005 The FSM SHALL have states BOOT, FETCH and HOLD; BOOT SHALL last exactly one cycle and then go to FETCH.
REQ-006 In FETCH, ImReq SHALL be 1 and ImAddr SHALL equal PC; in all other states ImReq SHALL be 0; ImAddr SHALL equal PC at all times.
REQ-007 ImAddr SHALL remain stable until ImAck; the request SHALL NOT be withdrawn before ImAck.
REQ-008 In FETCH, ImAck with no pending or same-cycle redirect SHALL, in the same cycle, drive PcEn=1 and NPC=PC+4.
REQ-009 On that same edge, the block SHALL capture Ir<=ImRdata and IrPc<=PC and go to HOLD.
REQ-010 PC+4 SHALL wrap modulo 2^32: 32'hFFFFFFFC -> 32'h00000000.
REQ-011 IrValid SHALL be 1 exactly when the state is HOLD; Ir and IrPc SHALL stay stable while IrValid=1 and IdReady=0.
REQ-012 In HOLD, IdReady=1 with no redirect SHALL move the FSM to FETCH on the next edge and increment RetCnt by 1; RetCnt SHALL wrap at 16'hFFFF -> 0.
REQ-013 Redirect address SHALL be EXC_VEC when ExcReq=1, otherwise RedirTarget; ExcReq SHALL win when both are asserted.
REQ-014 NPC bits [1:0] SHALL always be 00; RedirTarget[1:0] SHALL be ignored.
REQ-015 Redirect in BOOT or HOLD: same cycle PcEn=1 and NPC=redirect address; the FSM SHALL then go to FETCH.
REQ-016 A held instruction in HOLD SHALL be discarded on redirect, with no RetCnt increment even if IdReady=1 in that cycle.
REQ-017 Redirect in FETCH without ImAck: the block SHALL latch the redirect address into a pending register, set a kill flag, keep ImReq/ImAddr unchanged and keep PcEn=0.
REQ-018 A later redirect in FETCH SHALL overwrite the pending address, except that a non-exception redirect SHALL NOT overwrite a pending exception.
REQ-019 ImAck while the kill flag is set, or together with a same-cycle redirect, SHALL discard ImRdata and drive PcEn=1 with NPC=redirect address.
REQ-020 For REQ-019, a same-cycle ExcReq takes priority over a pending non-exception redirect; otherwise the pending address is used over a same-cycle RedirValid.
REQ-021 After REQ-019 the block SHALL clear the kill flag and stay in FETCH; the new request starts the following cycle at the new PC.
REQ-022 PcEn SHALL be 0 in every cycle not covered by REQ-008, REQ-015 or REQ-019.
REQ-023 NPC SHALL be combinational and meaningful only when PcEn=1; it SHALL equal PC+4 when PcEn=0.

Reset
REQ-024 Reset=1 SHALL immediately force state BOOT, ImReq=0, PcEn=0, IrValid=0, Ir=0, IrPc=RESET_PC, RetCnt=0, kill flag=0 and pending register=0.
REQ-025 Reset asserted mid-fetch SHALL abandon the outstanding request; an ImAck arriving during or after reset, before the first FETCH, SHALL be ignored.

Verification
REQ-026 Boot: release Reset, memory acks 2 cycles after each request, IdReady=1. Required: requests at 00003000, 00003004, 00003008; RetCnt=3 after three accepts.
REQ-027 Back-pressure: IdReady=0 for 5 cycles in HOLD. Required: IrValid=1, Ir/IrPc stable, ImReq=0, PcEn=0 throughout; advance on IdReady=1.
REQ-028 Redirect in flight: RedirValid with RedirTarget=00003103 one cycle before ImAck at PC=00003010. Required: word discarded, IrValid stays 0, NPC=00003100 with PcEn=1 on the ack cycle, next ImAddr=00003100.
REQ-029 Priority: ExcReq and RedirValid in the same HOLD cycle. Required: NPC=00004180 with PcEn=1, held instruction dropped, RetCnt unchanged.
REQ-030 Wrap: redirect to FFFFFFFC, then ack. Required: NPC=00000000 with PcEn=1, and IrPc=FFFFFFFC.
REQ-031 Reset mid-fetch: assert Reset while ImReq=1, then ack during Reset. Required: IrValid=0, RetCnt=0, and the first post-reset request addresses 00003000.
